// File: rtl/fifo_rd_drain.sv
// Purpose : drains a synchronous FIFO's read port into a registered valid/ready stream.
// Latency : two cycles from FIFO non-empty (buffer idle) to m_valid; one word/cycle sustained.
// Backpr. : 2-entry skid buffer; rd_en withheld whenever buffered + in-flight words would exceed 2.
//
// Ports
//   clk        sole clock, all state on the rising edge
//   rst        synchronous active-high reset
//   rd_en      FIFO read request (combinational from registered state, empty, m_ready)
//   data_out   FIFO read data, valid the cycle after an accepted rd_en
//   empty      FIFO empty flag
//   underflow  FIFO underflow flag, aligned with the data cycle of a bad read
//   m_valid    downstream word valid (registered)
//   m_data     downstream word (registered)
//   m_ready    downstream accept
//   err        sticky underflow error, only when FIFO_RD_ERR_EN is defined
//
// Build option: define FIFO_RD_ERR_EN to add the sticky err output.

module fifo_rd_drain #(
    parameter int FIFO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  empty,
    input  logic                  underflow,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef FIFO_RD_ERR_EN
    ,
    output logic                  err
`endif
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]            r_occ;        // words held in the skid buffer (0..2)
    logic                  r_inflight;   // rd_en was accepted last cycle
    logic [FIFO_WIDTH-1:0] r_buf [2];
    logic                  r_head;
    logic                  r_tail;
    logic                  r_m_valid;
    logic [FIFO_WIDTH-1:0] r_m_data;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    logic                  w_pop;
    logic                  w_cap;
    logic [2:0]            w_level;
    logic [1:0]            w_occ_nxt;
    logic                  w_head_nxt;
    logic                  w_tail_nxt;
    logic [FIFO_WIDTH-1:0] w_buf0_nxt;
    logic [FIFO_WIDTH-1:0] w_buf1_nxt;
    logic [FIFO_WIDTH-1:0] w_m_data_nxt;

    assign w_pop = r_m_valid && m_ready;

    // An underflowed read returns garbage; it is dropped rather than buffered.
    assign w_cap = r_inflight && !underflow;

    // Words that will still need a slot after this edge. A pop frees a slot
    // in the same cycle, which is why m_ready reaches rd_en combinationally.
    // pop implies occ >= 1, so this never goes negative.
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign rd_en = !rst && !empty && (w_level < 3'd2);

    // occ + inflight never exceeds 2, so occ_nxt stays within 0..2.
    assign w_occ_nxt  = r_occ + {1'b0, w_cap} - {1'b0, w_pop};
    assign w_head_nxt = w_pop ? ~r_head : r_head;
    assign w_tail_nxt = w_cap ? ~r_tail : r_tail;

    // The captured word always lands in a free slot: when occ == 1 the tail
    // differs from the head, so the word being presented is never overwritten.
    assign w_buf0_nxt = (w_cap && (r_tail == 1'b0)) ? data_out : r_buf[0];
    assign w_buf1_nxt = (w_cap && (r_tail == 1'b1)) ? data_out : r_buf[1];

    // Output register is loaded from the post-update head so a word captured
    // into an empty buffer is presented on the very next cycle.
    assign w_m_data_nxt = w_head_nxt ? w_buf1_nxt : w_buf0_nxt;

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_inflight <= rd_en;
            r_buf[0]   <= w_buf0_nxt;
            r_buf[1]   <= w_buf1_nxt;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_m_valid  <= (w_occ_nxt != 2'd0);
            r_m_data   <= w_m_data_nxt;
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;

`ifdef FIFO_RD_ERR_EN
    // ------------------------------------------------------------------
    // Sticky underflow error: set on the data cycle of a bad read, held
    // until reset so software can observe it after the fact.
    // ------------------------------------------------------------------
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_inflight && underflow) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
module tb_fifo_rd_drain;

    localparam int W = 16;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         rd_en;
    logic [W-1:0] data_out  = '0;
    logic         empty;
    logic         underflow = 1'b0;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_ready   = 1'b0;
`ifdef FIFO_RD_ERR_EN
    logic         err;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural FIFO: one-cycle read latency, contents written by the stimulus.
    logic [W-1:0] mem [256];
    int wptr = 0;
    int rptr = 0;

    always #5 clk = ~clk;

    assign empty = (wptr == rptr);

    always @(posedge clk) begin
        if (rd_en && !empty) begin
            data_out <= mem[rptr[7:0]];
            rptr     <= rptr + 1;
        end
    end

    fifo_rd_drain #(.FIFO_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .empty     (empty),
        .underflow (underflow),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready)
`ifdef FIFO_RD_ERR_EN
        ,
        .err       (err)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wptr[7:0]] = W'(first + i);
            wptr = wptr + 1;
        end
    endtask

    int pulses;
    int got;
    int reads;
    int pops;
    int maxout;

    initial begin
        // ---------------- reset with FIFO non-empty ----------------
        load(1, 8);
        for (int c = 0; c < 2; c++) begin
            tick;
            check("rst_rd_en", 32'(rd_en), 32'd0);
            check("rst_m_valid", 32'(m_valid), 32'd0);
            check("rst_m_data", 32'(m_data), 32'd0);
`ifdef FIFO_RD_ERR_EN
            check("rst_err", 32'(err), 32'd0);
`endif
        end

        // ---------------- streaming, m_ready high ----------------
        rst     = 1'b0;
        m_ready = 1'b1;
        settle;
        check("lat_rd_en", 32'(rd_en), 32'd1);
        check("lat_vld_n0", 32'(m_valid), 32'd0);
        tick;
        check("lat_vld_n1", 32'(m_valid), 32'd0);
        tick;
        for (int i = 1; i <= 8; i++) begin
            check("stream_vld", 32'(m_valid), 32'd1);
            check("stream_data", 32'(m_data), 32'(i));
            tick;
        end
        check("stream_end_vld", 32'(m_valid), 32'd0);
        check("stream_end_rd", 32'(rd_en), 32'd0);

        // ---------------- back-pressure ----------------
        m_ready = 1'b0;
        load(1, 8);
        settle;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (rd_en) pulses++;
            tick;
        end
        check("bp_pulses", 32'(pulses), 32'd2);
        check("bp_vld", 32'(m_valid), 32'd1);
        check("bp_hold", 32'(m_data), 32'h0001);
        m_ready = 1'b1;
        settle;
        got = 0;
        for (int c = 0; c < 30 && got < 8; c++) begin
            if (m_valid) begin
                check("bp_word", 32'(m_data), 32'(got + 1));
                got++;
            end
            tick;
        end
        check("bp_count", 32'(got), 32'd8);
        tick;
        check("bp_idle", 32'(m_valid), 32'd0);

        // ---------------- alternating m_ready ----------------
        load(1, 6);
        got    = 0;
        reads  = 0;
        pops   = 0;
        maxout = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            m_ready = (c % 2 == 0);
            settle;
            if (rd_en) reads++;
            if (m_valid && m_ready) begin
                check("alt_word", 32'(m_data), 32'(got + 1));
                got++;
                pops++;
            end
            if (reads - pops > maxout) maxout = reads - pops;
            tick;
        end
        check("alt_count", 32'(got), 32'd6);
        check("alt_max_outstanding", 32'(maxout <= 2), 32'd1);
        m_ready = 1'b1;
        tick;
        check("alt_idle", 32'(m_valid), 32'd0);

        // ---------------- forced underflow ----------------
        load(16'h00AA, 1);
        settle;
        check("uf_rd_en", 32'(rd_en), 32'd1);
        tick;
        underflow = 1'b1;
        tick;
        underflow = 1'b0;
        settle;
        check("uf_drop", 32'(m_valid), 32'd0);
`ifdef FIFO_RD_ERR_EN
        check("uf_err_set", 32'(err), 32'd1);
`endif
        tick;
        tick;
        tick;
        check("uf_still_empty", 32'(m_valid), 32'd0);
`ifdef FIFO_RD_ERR_EN
        check("uf_err_sticky", 32'(err), 32'd1);
`endif
        load(16'h00BB, 1);
        settle;
        tick;
        tick;
        check("uf_next_vld", 32'(m_valid), 32'd1);
        check("uf_next_data", 32'(m_data), 32'h00BB);
        tick;

        // ---------------- reset mid-stream ----------------
        m_ready = 1'b0;
        load(16'h0011, 8);
        settle;
        tick;
        tick;
        check("mid_pre_vld", 32'(m_valid), 32'd1);
        check("mid_pre_data", 32'(m_data), 32'h0011);
        rst = 1'b1;
        settle;
        check("mid_rst_rd_en", 32'(rd_en), 32'd0);
        tick;
        rst     = 1'b0;
        m_ready = 1'b1;
        settle;
        check("mid_vld_cleared", 32'(m_valid), 32'd0);
        check("mid_data_cleared", 32'(m_data), 32'd0);
`ifdef FIFO_RD_ERR_EN
        check("mid_err_cleared", 32'(err), 32'd0);
`endif
        check("mid_resume_rd", 32'(rd_en), 32'd1);
        got = 0;
        for (int c = 0; c < 20 && got < 6; c++) begin
            if (m_valid) begin
                check("mid_word", 32'(m_data), 32'(16'h0013 + got));
                got++;
            end
            tick;
        end
        check("mid_count", 32'(got), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
